timed_step_sequencer: RTL and testbench
=======================================

Name: timed_step_sequencer

Overview:
- Controller that drives one `counter_overflow` timer through a programmable list of step durations.
- It consumes the timer's overflow flag and produces the timer's limit and reset, for multi-phase program-control timing (e.g. light phases, stage timeouts).
- Holds a small writable duration table and advances one step per timer expiry, optionally looping.

Parameters:
- COUNTER_BITS, 32, width of a duration and of the timer limit
- STEPS, 4, number of steps in the table (2..16)
- STEP_BITS, 2, index width; must equal clog2(STEPS)

Ports:
- i_CLK  input  1  clock; all logic on its rising edge
- i_RST  input  1  reset, synchronous, active-high
- i_START  input  1  start request, sampled only in IDLE
- i_STOP  input  1  abort request, any state
- i_LOOP  input  1  1: wrap from last step to step 0; sampled at each last-step expiry
- i_DUR_WE  input  1  duration table write enable
- i_DUR_ADDR  input  STEP_BITS  table write index
- i_DUR_DATA  input  COUNTER_BITS  table write data
- i_OVERFLOW  input  1  overflow flag from the timer
- o_CNT_LIM  output  COUNTER_BITS  limit driven to the timer
- o_CNT_RST  output  1  reset driven to the timer; registered
- o_STEP  output  STEP_BITS  current step index
- o_BUSY  output  1  high in every state except IDLE
- o_STEP_DONE  output  1  one-cycle pulse per completed step
- o_SEQ_DONE  output  1  one-cycle pulse when a non-looping sequence finishes

Behaviour:
- States:
  - IDLE: o_CNT_RST=1.
  - LOAD: o_CNT_RST=1; o_CNT_LIM <= table[o_STEP].
  - ARM: o_CNT_RST=0; i_OVERFLOW ignored.
  - RUN: o_CNT_RST=0; waits for i_OVERFLOW.
- Reset values: state IDLE, o_CNT_LIM=0, o_CNT_RST=1, o_STEP=0, o_BUSY=0, pulses 0, all table entries 0.
- Transitions:
  - IDLE -> LOAD when i_START=1; o_STEP <= 0.
  - LOAD -> ARM -> RUN, one cycle each.
  - RUN, i_OVERFLOW=1, o_STEP<STEPS-1: o_STEP_DONE=1 next cycle; o_STEP <= o_STEP+1; -> LOAD.
  - RUN, i_OVERFLOW=1, o_STEP=STEPS-1, i_LOOP=1: o_STEP_DONE=1; o_STEP <= 0; -> LOAD.
  - RUN, i_OVERFLOW=1, o_STEP=STEPS-1, i_LOOP=0: o_STEP_DONE=1 and o_SEQ_DONE=1 in the same cycle; o_STEP holds last index; -> IDLE.
- Latency: i_START sampled at edge N -> LOAD at N+1 -> ARM N+2 -> RUN N+3. Step overhead is 3 cycles beyond the timer's own count.
- o_CNT_LIM is latched only in LOAD. Table writes during RUN never alter a running step; they take effect at the next LOAD of that index.
- Table write and read of the same entry in the same cycle: LOAD takes the old value.
- o_CNT_RST held high in IDLE keeps the timer cleared, so i_OVERFLOW is low on start. Stale overflow is masked by the ARM cycle.
- Priority: i_RST > i_STOP > expiry > i_START.
  - i_STOP in any busy state: -> IDLE next cycle; o_STEP <= 0; no done pulses.
  - i_STOP in IDLE: no effect.
- i_START while busy: ignored; no restart or queueing.
- i_RST mid-sequence: full reset values, including the table.
- o_STEP increment wraps within STEP_BITS; STEPS not a power of two wraps explicitly at STEPS-1.

Optional Feature:
- Macro: SEQ_SKIP_ZERO_EN.
- Defined:
  - A step whose table entry is 0 is skipped in LOAD.
  - o_STEP_DONE pulses and the advance/loop/finish decision is taken directly from LOAD, without entering ARM/RUN.
  - Costs 1 cycle per skipped step.
  - All-zero table with i_LOOP=1 cycles indefinitely, with o_STEP_DONE high continuously until i_STOP.
- Undefined: a zero entry runs normally (timer expires after its minimum count).

Decomposition:
- Shared package/include seq_pkg: state encodings (IDLE=2'd0, LOAD=2'd1, ARM=2'd2, RUN=2'd3) and the STEP_BITS derivation.
- One sub-module: step_duration_rf, a STEPS x COUNTER_BITS register file with a synchronous write port and an asynchronous read port, synchronously reset to 0.

Test Plan:
- Bench timer model: overflow rises LIM+1 cycles after o_CNT_RST falls.
- Table {3,5,2,4}, i_LOOP=0, START pulse -> o_STEP 0,1,2,3; four o_STEP_DONE pulses spaced 7,9,6,8 cycles apart; o_SEQ_DONE coincides with the 4th; o_BUSY falls.
- Same table, i_LOOP=1 -> after step 3, o_STEP returns to 0 with o_CNT_LIM=3; no o_SEQ_DONE.
- i_STOP during RUN of step 1 -> IDLE next cycle; o_CNT_RST=1, o_STEP=0; no done pulse.
- Write table[1]=9 during RUN of step 1 (LIM 5) -> current step still expires on 5; the next pass loads 9.
- i_START asserted while busy -> ignored, sequence timing unchanged. i_RST during RUN -> all outputs and table at reset values next cycle.
- SEQ_SKIP_ZERO_EN, table {3,0,0,2} -> steps 1 and 2 each produce a 1-cycle o_STEP_DONE with o_CNT_RST held high throughout.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the timed step sequencer: controller state encoding
// and the step-index width derivation.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ARM  = 2'd2,
    RUN  = 2'd3
  } seq_state_t;

  function automatic int step_bits_for(input int steps);
    return $clog2(steps);
  endfunction

endpackage

// File: rtl/timed_step_sequencer_if.sv
// Command/status bundle between the timed step sequencer and its controller.
// Also carries the overflow-timer handshake.
interface timed_step_sequencer_if #(
  parameter int COUNTER_BITS = 32,
  parameter int STEP_BITS    = seq_pkg::step_bits_for(4)
);
  logic                    i_START;
  logic                    i_STOP;
  logic                    i_LOOP;
  logic                    i_DUR_WE;
  logic [STEP_BITS-1:0]    i_DUR_ADDR;
  logic [COUNTER_BITS-1:0] i_DUR_DATA;
  logic                    i_OVERFLOW;
  logic [COUNTER_BITS-1:0] o_CNT_LIM;
  logic                    o_CNT_RST;
  logic [STEP_BITS-1:0]    o_STEP;
  logic                    o_BUSY;
  logic                    o_STEP_DONE;
  logic                    o_SEQ_DONE;

  modport master (
    output i_START, i_STOP, i_LOOP, i_DUR_WE, i_DUR_ADDR, i_DUR_DATA, i_OVERFLOW,
    input  o_CNT_LIM, o_CNT_RST, o_STEP, o_BUSY, o_STEP_DONE, o_SEQ_DONE
  );

  modport slave (
    input  i_START, i_STOP, i_LOOP, i_DUR_WE, i_DUR_ADDR, i_DUR_DATA, i_OVERFLOW,
    output o_CNT_LIM, o_CNT_RST, o_STEP, o_BUSY, o_STEP_DONE, o_SEQ_DONE
  );
endinterface

// File: rtl/timed_step_sequencer_rf.sv
// Step duration table: synchronous write port, asynchronous read port,
// synchronously cleared to zero.
module step_duration_rf #(
  parameter int STEPS        = 4,
  parameter int COUNTER_BITS = 32,
  parameter int STEP_BITS    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [STEP_BITS-1:0]    waddr,
  input  logic [COUNTER_BITS-1:0] wdata,
  input  logic [STEP_BITS-1:0]    raddr,
  output logic [COUNTER_BITS-1:0] rdata
);

  logic [COUNTER_BITS-1:0] mem_r [STEPS];

  // Table storage; writes beyond the last step are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STEPS; i++) begin
        mem_r[i] <= {COUNTER_BITS{1'b0}};
      end
    end else if (we && (int'(waddr) < STEPS)) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Asynchronous read so LOAD sees the pre-write value of a same-cycle write
  always_comb begin
    rdata = {COUNTER_BITS{1'b0}};
    if (int'(raddr) < STEPS) begin
      rdata = mem_r[raddr];
    end else begin
      rdata = {COUNTER_BITS{1'b0}};
    end
  end

endmodule

// File: rtl/timed_step_sequencer.sv
// Drives an overflow timer through a table of step durations, optionally looping.
// Optional build macro SEQ_SKIP_ZERO_EN: zero-duration steps are skipped in LOAD.
module timed_step_sequencer
  import seq_pkg::*;
#(
  parameter int COUNTER_BITS = 32,
  parameter int STEPS        = 4,
  parameter int STEP_BITS    = step_bits_for(STEPS)
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  timed_step_sequencer_if.slave bus
);

  localparam logic [STEP_BITS-1:0] LAST_STEP = STEP_BITS'(STEPS - 1);

  seq_state_t              state_r;
  logic [STEP_BITS-1:0]    step_r;
  logic [COUNTER_BITS-1:0] lim_r;
  logic                    cnt_rst_r;
  logic                    busy_r;
  logic                    step_done_r;
  logic                    seq_done_r;

  logic [COUNTER_BITS-1:0] rd_data_s;
  logic                    skip_s;
  seq_state_t              adv_state_s;
  logic [STEP_BITS-1:0]    adv_step_s;
  logic                    adv_seq_done_s;
  logic                    adv_busy_s;

  step_duration_rf #(
    .STEPS       (STEPS),
    .COUNTER_BITS(COUNTER_BITS),
    .STEP_BITS   (STEP_BITS)
  ) u_rf (
    .clk  (i_CLK),
    .rst  (i_RST),
    .we   (bus.i_DUR_WE),
    .waddr(bus.i_DUR_ADDR),
    .wdata(bus.i_DUR_DATA),
    .raddr(step_r),
    .rdata(rd_data_s)
  );

`ifdef SEQ_SKIP_ZERO_EN
  assign skip_s = (rd_data_s == {COUNTER_BITS{1'b0}});
`else
  assign skip_s = 1'b0;
`endif

  // Where a completed step leads: next index, wrap to 0, or finish
  always_comb begin
    adv_state_s    = LOAD;
    adv_step_s     = step_r;
    adv_seq_done_s = 1'b0;
    adv_busy_s     = 1'b1;
    if (step_r != LAST_STEP) begin
      adv_step_s = step_r + STEP_BITS'(1);
    end else if (bus.i_LOOP) begin
      adv_step_s = {STEP_BITS{1'b0}};
    end else begin
      adv_state_s    = IDLE;
      adv_seq_done_s = 1'b1;
      adv_busy_s     = 1'b0;
    end
  end

  // Sequencer FSM with registered timer controls and status pulses
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_r     <= IDLE;
      step_r      <= {STEP_BITS{1'b0}};
      lim_r       <= {COUNTER_BITS{1'b0}};
      cnt_rst_r   <= 1'b1;
      busy_r      <= 1'b0;
      step_done_r <= 1'b0;
      seq_done_r  <= 1'b0;
    end else begin
      step_done_r <= 1'b0;
      seq_done_r  <= 1'b0;
      if (bus.i_STOP && (state_r != IDLE)) begin
        state_r   <= IDLE;
        step_r    <= {STEP_BITS{1'b0}};
        cnt_rst_r <= 1'b1;
        busy_r    <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (bus.i_START) begin
              state_r <= LOAD;
              step_r  <= {STEP_BITS{1'b0}};
              busy_r  <= 1'b1;
            end
            cnt_rst_r <= 1'b1;
          end
          LOAD: begin
            if (skip_s) begin
              state_r     <= adv_state_s;
              step_r      <= adv_step_s;
              busy_r      <= adv_busy_s;
              step_done_r <= 1'b1;
              seq_done_r  <= adv_seq_done_s;
              cnt_rst_r   <= 1'b1;
            end else begin
              state_r   <= ARM;
              lim_r     <= rd_data_s;
              cnt_rst_r <= 1'b0;
            end
          end
          // Timer has just been released; any overflow seen here is stale
          ARM: begin
            state_r <= RUN;
          end
          RUN: begin
            if (bus.i_OVERFLOW) begin
              state_r     <= adv_state_s;
              step_r      <= adv_step_s;
              busy_r      <= adv_busy_s;
              step_done_r <= 1'b1;
              seq_done_r  <= adv_seq_done_s;
              cnt_rst_r   <= 1'b1;
            end
          end
          default: begin
            state_r   <= IDLE;
            step_r    <= {STEP_BITS{1'b0}};
            cnt_rst_r <= 1'b1;
            busy_r    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.o_CNT_LIM   = lim_r;
  assign bus.o_CNT_RST   = cnt_rst_r;
  assign bus.o_STEP      = step_r;
  assign bus.o_BUSY      = busy_r;
  assign bus.o_STEP_DONE = step_done_r;
  assign bus.o_SEQ_DONE  = seq_done_r;

endmodule

// File: tb/tb_timed_step_sequencer.sv
// Self-checking bench for timed_step_sequencer: behavioural timer, pulse/limit
// monitor and a step-list reference model derived from the duration table.
module tb_timed_step_sequencer;

  localparam int CB    = 32;
  localparam int STEPS = 4;
  localparam int SB    = 2;

  typedef logic [CB-1:0] tbl_t [STEPS];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  timed_step_sequencer_if #(.COUNTER_BITS(CB), .STEP_BITS(SB)) bus ();

  timed_step_sequencer #(.COUNTER_BITS(CB), .STEPS(STEPS), .STEP_BITS(SB)) dut (
    .i_CLK(clk),
    .i_RST(rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  // Timer: counts cycles with reset low, registered overflow once count exceeds LIM
  longint unsigned tcnt = 0;
  always @(posedge clk) begin
    if (bus.o_CNT_RST !== 1'b0) begin
      tcnt           <= 0;
      bus.i_OVERFLOW <= 1'b0;
    end else begin
      tcnt           <= tcnt + 1;
      bus.i_OVERFLOW <= (tcnt >= longint'(bus.o_CNT_LIM) + 1);
    end
  end

  // Monitor: done pulses and the limit handed to the timer at each release
  int            pt[$];
  logic [SB-1:0] ps[$];
  logic          pq[$];
  logic          pd[$];
  logic [CB-1:0] lims[$];
  logic          prev_rst = 1'b1;
  always @(negedge clk) begin
    if (bus.o_STEP_DONE === 1'b1 || bus.o_SEQ_DONE === 1'b1) begin
      pt.push_back(cyc);
      ps.push_back(bus.o_STEP);
      pq.push_back(bus.o_SEQ_DONE);
      pd.push_back(bus.o_STEP_DONE);
    end
    if (prev_rst === 1'b1 && bus.o_CNT_RST === 1'b0) lims.push_back(bus.o_CNT_LIM);
    prev_rst = bus.o_CNT_RST;
  end

  // Reference model expectations
  int            et[$];
  logic [SB-1:0] es[$];
  logic          eq[$];
  logic [CB-1:0] el[$];

  function automatic void build_model(input tbl_t a, input tbl_t b, input logic loop,
                                      input int start_edge, input int n);
    int t = start_edge;
    et.delete(); es.delete(); eq.delete(); el.delete();
    for (int k = 0; k < n; k++) begin
      int s = k % STEPS;
      logic [CB-1:0] d = (k < STEPS) ? a[s] : b[s];
      logic last = (s == STEPS - 1);
`ifdef SEQ_SKIP_ZERO_EN
      if (d == 0) t += 1;
      else begin
        t += int'(d) + 4;
        el.push_back(d);
      end
`else
      t += int'(d) + 4;
      el.push_back(d);
`endif
      et.push_back(t);
      es.push_back(last ? (loop ? SB'(0) : SB'(STEPS - 1)) : SB'(s + 1));
      eq.push_back(last && !loop);
      if (last && !loop) break;
    end
  endfunction

  task automatic clear_mon();
    pt.delete(); ps.delete(); pq.delete(); pd.delete(); lims.delete();
  endtask

  task automatic write_entry(input int idx, input logic [CB-1:0] val);
    @(negedge clk); #1;
    bus.i_DUR_WE   = 1'b1;
    bus.i_DUR_ADDR = SB'(idx);
    bus.i_DUR_DATA = val;
    @(negedge clk); #1;
    bus.i_DUR_WE   = 1'b0;
  endtask

  task automatic start_seq(input logic loop, output int start_edge);
    @(negedge clk); #1;
    bus.i_LOOP  = loop;
    bus.i_START = 1'b1;
    start_edge  = cyc + 1;
    clear_mon();
    @(negedge clk); #1;
    bus.i_START = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks += 6;
    if (bus.o_CNT_LIM !== 32'd0) begin n_fail++; $display("FAIL reset lim: got %0d expected 0", bus.o_CNT_LIM); end
    if (bus.o_CNT_RST !== 1'b1) begin n_fail++; $display("FAIL reset cnt_rst: got %b expected 1", bus.o_CNT_RST); end
    if (bus.o_STEP !== 2'd0) begin n_fail++; $display("FAIL reset step: got %0d expected 0", bus.o_STEP); end
    if (bus.o_BUSY !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", bus.o_BUSY); end
    if (bus.o_STEP_DONE !== 1'b0) begin n_fail++; $display("FAIL reset step_done: got %b expected 0", bus.o_STEP_DONE); end
    if (bus.o_SEQ_DONE !== 1'b0) begin n_fail++; $display("FAIL reset seq_done: got %b expected 0", bus.o_SEQ_DONE); end
    rst = 1'b0;
  endtask

  // One sequence run against the model; optional mid-run write and busy-start noise
  task automatic test_sequence(input string name, input logic prog, input tbl_t a, input tbl_t b,
                               input logic loop, input int npulse, input int wr_step,
                               input logic noise);
    int   start_edge;
    logic ok = 1'b0;
    logic wrote = 1'b0;
    if (prog) for (int i = 0; i < STEPS; i++) write_entry(i, a[i]);
    start_seq(loop, start_edge);
    build_model(a, b, loop, start_edge, npulse);
    for (int c = 0; c < 800; c++) begin
      @(negedge clk); #1;
      if (pt.size() >= et.size()) begin ok = 1'b1; break; end
      bus.i_START = (noise && bus.o_BUSY === 1'b1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (wr_step >= 0 && !wrote && bus.o_STEP == SB'(wr_step) && bus.o_CNT_RST === 1'b0) begin
        bus.i_DUR_WE   = 1'b1;
        bus.i_DUR_ADDR = SB'(wr_step);
        bus.i_DUR_DATA = b[wr_step];
        wrote          = 1'b1;
      end else begin
        bus.i_DUR_WE = 1'b0;
      end
    end
    bus.i_START  = 1'b0;
    bus.i_DUR_WE = 1'b0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL %s timeout: got %0d pulses expected %0d", name, pt.size(), et.size()); end
    if (loop) begin
      bus.i_STOP = 1'b1;
      @(negedge clk); #1;
      bus.i_STOP = 1'b0;
    end
    repeat (3) @(negedge clk);
    #1;
    n_checks += 3;
    if (pt.size() != et.size()) begin n_fail++; $display("FAIL %s pulse count: got %0d expected %0d", name, pt.size(), et.size()); end
    if (lims.size() != el.size()) begin n_fail++; $display("FAIL %s limit count: got %0d expected %0d", name, lims.size(), el.size()); end
    if (bus.o_BUSY !== 1'b0) begin n_fail++; $display("FAIL %s busy at end: got %b expected 0", name, bus.o_BUSY); end
    for (int i = 0; i < pt.size() && i < et.size(); i++) begin
      n_checks += 4;
      if (pt[i] != et[i]) begin n_fail++; $display("FAIL %s pulse%0d cycle: got %0d expected %0d", name, i, pt[i], et[i]); end
      if (ps[i] !== es[i]) begin n_fail++; $display("FAIL %s pulse%0d step: got %0d expected %0d", name, i, ps[i], es[i]); end
      if (pq[i] !== eq[i]) begin n_fail++; $display("FAIL %s pulse%0d seq_done: got %b expected %b", name, i, pq[i], eq[i]); end
      if (pd[i] !== 1'b1) begin n_fail++; $display("FAIL %s pulse%0d step_done: got %b expected 1", name, i, pd[i]); end
    end
    for (int i = 0; i < lims.size() && i < el.size(); i++) begin
      n_checks++;
      if (lims[i] !== el[i]) begin n_fail++; $display("FAIL %s limit%0d: got %0d expected %0d", name, i, lims[i], el[i]); end
    end
  endtask

  task automatic reach_run_step1(input string name);
    int   start_edge;
    logic found = 1'b0;
    for (int i = 0; i < STEPS; i++) write_entry(i, (i == 1) ? 32'd20 : 32'd3);
    start_seq(1'b0, start_edge);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); #1;
      if (bus.o_STEP === 2'd1 && bus.o_CNT_RST === 1'b0) begin found = 1'b1; break; end
    end
    @(negedge clk); #1;
    clear_mon();
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL %s reach step1: got step %0d expected 1", name, bus.o_STEP); end
  endtask

  task automatic test_stop();
    reach_run_step1("stop");
    bus.i_STOP = 1'b1;
    @(negedge clk); #1;
    bus.i_STOP = 1'b0;
    n_checks += 4;
    if (bus.o_BUSY !== 1'b0) begin n_fail++; $display("FAIL stop busy: got %b expected 0", bus.o_BUSY); end
    if (bus.o_CNT_RST !== 1'b1) begin n_fail++; $display("FAIL stop cnt_rst: got %b expected 1", bus.o_CNT_RST); end
    if (bus.o_STEP !== 2'd0) begin n_fail++; $display("FAIL stop step: got %0d expected 0", bus.o_STEP); end
    if (pt.size() != 0) begin n_fail++; $display("FAIL stop pulse: got %0d pulses expected 0", pt.size()); end
    repeat (30) @(negedge clk);
    #1;
    n_checks += 2;
    if (bus.o_BUSY !== 1'b0) begin n_fail++; $display("FAIL stop stays idle: got busy %b expected 0", bus.o_BUSY); end
    if (pt.size() != 0) begin n_fail++; $display("FAIL stop later pulse: got %0d pulses expected 0", pt.size()); end
  endtask

  task automatic test_reset_mid();
    tbl_t z = '{default: 32'd0};
    reach_run_step1("reset_mid");
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    n_checks += 5;
    if (bus.o_CNT_LIM !== 32'd0) begin n_fail++; $display("FAIL reset_mid lim: got %0d expected 0", bus.o_CNT_LIM); end
    if (bus.o_CNT_RST !== 1'b1) begin n_fail++; $display("FAIL reset_mid cnt_rst: got %b expected 1", bus.o_CNT_RST); end
    if (bus.o_STEP !== 2'd0) begin n_fail++; $display("FAIL reset_mid step: got %0d expected 0", bus.o_STEP); end
    if (bus.o_BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_mid busy: got %b expected 0", bus.o_BUSY); end
    if (pt.size() != 0) begin n_fail++; $display("FAIL reset_mid pulse: got %0d expected 0", pt.size()); end
    test_sequence("cleared_table", 1'b0, z, z, 1'b0, STEPS, -1, 1'b0);
  endtask

  initial begin
    tbl_t base = '{32'd3, 32'd5, 32'd2, 32'd4};
    tbl_t upd  = '{32'd3, 32'd9, 32'd2, 32'd4};
    tbl_t zer  = '{32'd3, 32'd0, 32'd0, 32'd2};
    tbl_t rnd;
    logic rl;
    bus.i_START = 1'b0; bus.i_STOP = 1'b0; bus.i_LOOP = 1'b0;
    bus.i_DUR_WE = 1'b0; bus.i_DUR_ADDR = '0; bus.i_DUR_DATA = '0;
    test_reset();
    test_sequence("single_pass", 1'b1, base, base, 1'b0, STEPS, -1, 1'b0);
    test_sequence("loop", 1'b1, base, base, 1'b1, 6, -1, 1'b0);
    test_sequence("table_write", 1'b1, base, upd, 1'b1, 6, 1, 1'b0);
    test_sequence("back_to_back_start", 1'b1, base, base, 1'b0, STEPS, -1, 1'b1);
    test_sequence("zero_entries", 1'b1, zer, zer, 1'b0, STEPS, -1, 1'b0);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < STEPS; i++) rnd[i] = CB'($urandom_range(0, 6));
      rl = 1'($urandom_range(0, 1));
      test_sequence("random", 1'b1, rnd, rnd, rl, rl ? 7 : STEPS, -1, 1'b1);
    end
    test_stop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
